// File: rtl/hapara_icap_sched.sv
// hapara_icap_sched: round-robin owner of the single ICAPE2 write port. Streams
// one BRAM-held partial bitstream per grant, one 32-bit word per cycle.
module hapara_icap_sched #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter bit SWAP_BITS  = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_len,
    output logic [NUM_REQ-1:0]            req_ack,
    output logic [NUM_REQ-1:0]            req_done,
    output logic                          busy,
    output logic                          bram_en,
    output logic [ADDR_WIDTH-1:0]         bram_addr,
    input  logic [DATA_WIDTH-1:0]         bram_dout,
    output logic                          icap_csib,
    output logic                          icap_rdwrb,
    output logic [DATA_WIDTH-1:0]         icap_i,
    output logic [31:0]                   word_cnt
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [PW-1:0]           ptr_q, ptr_d;
    logic [PW-1:0]           gnt_q, gnt_d;
    logic [ADDR_WIDTH-1:0]   rem_q, rem_d;
    logic                    drain_q, drain_d;
    logic [NUM_REQ-1:0]      req_ack_q, req_ack_d;
    logic [NUM_REQ-1:0]      req_done_q, req_done_d;
    logic                    busy_q, busy_d;
    logic                    bram_en_q, bram_en_d;
    logic [ADDR_WIDTH-1:0]   bram_addr_q, bram_addr_d;
    logic                    rd_vld_q, rd_vld_d;
    logic                    icap_csib_q, icap_csib_d;
    logic [DATA_WIDTH-1:0]   icap_i_q, icap_i_d;
    logic [31:0]             word_cnt_q, word_cnt_d;

    logic [ADDR_WIDTH-1:0]   addr_arr [NUM_REQ];
    logic [ADDR_WIDTH-1:0]   len_arr  [NUM_REQ];
    logic                    gnt_found;
    logic [PW-1:0]           gnt_idx;
    logic [PW:0]             cand;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [ADDR_WIDTH-1:0]   sel_len;

    function automatic logic [DATA_WIDTH-1:0] bit_swap(input logic [DATA_WIDTH-1:0] w);
        logic [DATA_WIDTH-1:0] r;
        r = '0;
        for (int unsigned j = 0; j < DATA_WIDTH / 8; j++) begin
            for (int unsigned b = 0; b < 8; b++) begin
                r[8*j+b] = w[8*j+7-b];
            end
        end
        return r;
    endfunction

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            addr_arr[i] = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            len_arr[i]  = req_len[i*ADDR_WIDTH +: ADDR_WIDTH];
        end
    end

    // Scan from the pointer upward with wrap; the extra bit of cand absorbs ptr+i overflow.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr_q} + (PW+1)'(i);
            if (cand >= (PW+1)'(NUM_REQ)) begin
                cand = cand - (PW+1)'(NUM_REQ);
            end
            if (!gnt_found && req_valid[cand[PW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[PW-1:0];
            end
        end
        sel_addr = addr_arr[gnt_idx];
        sel_len  = len_arr[gnt_idx];
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        rem_d       = rem_q;
        drain_d     = drain_q;
        req_ack_d   = '0;
        req_done_d  = '0;
        busy_d      = busy_q;
        bram_en_d   = 1'b0;
        bram_addr_d = bram_addr_q;

        case (state_q)
            IDLE: begin
                if (gnt_found) begin
                    gnt_d              = gnt_idx;
                    ptr_d              = (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + PW'(1);
                    req_ack_d[gnt_idx] = 1'b1;
                    busy_d             = 1'b1;
                    if (sel_len == '0) begin
                        // Zero-length: skip straight to the last drain cycle so done follows ack.
                        state_d = DRAIN;
                        drain_d = 1'b1;
                    end else begin
                        state_d     = READ;
                        bram_en_d   = 1'b1;
                        bram_addr_d = sel_addr;
                        rem_d       = sel_len;
                    end
                end
            end
            READ: begin
                if (rem_q <= ADDR_WIDTH'(1)) begin
                    state_d = DRAIN;
                    drain_d = 1'b0;
                end else begin
                    bram_en_d   = 1'b1;
                    bram_addr_d = bram_addr_q + ADDR_WIDTH'(1);
                    rem_d       = rem_q - ADDR_WIDTH'(1);
                end
            end
            DRAIN: begin
                if (drain_q) begin
                    state_d           = DONE;
                    req_done_d[gnt_q] = 1'b1;
                end else begin
                    drain_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    // Two-stage write pipeline: BRAM read latency, then the registered ICAP stage.
    always_comb begin
        rd_vld_d    = bram_en_q;
        icap_csib_d = !rd_vld_q;
        icap_i_d    = icap_i_q;
        if (rd_vld_q) begin
            icap_i_d = SWAP_BITS ? bit_swap(bram_dout) : bram_dout;
        end
        word_cnt_d = word_cnt_q + 32'(!icap_csib_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            gnt_q       <= '0;
            rem_q       <= '0;
            drain_q     <= 1'b0;
            req_ack_q   <= '0;
            req_done_q  <= '0;
            busy_q      <= 1'b0;
            bram_en_q   <= 1'b0;
            bram_addr_q <= '0;
            rd_vld_q    <= 1'b0;
            icap_csib_q <= 1'b1;
            icap_i_q    <= '0;
            word_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            rem_q       <= rem_d;
            drain_q     <= drain_d;
            req_ack_q   <= req_ack_d;
            req_done_q  <= req_done_d;
            busy_q      <= busy_d;
            bram_en_q   <= bram_en_d;
            bram_addr_q <= bram_addr_d;
            rd_vld_q    <= rd_vld_d;
            icap_csib_q <= icap_csib_d;
            icap_i_q    <= icap_i_d;
            word_cnt_q  <= word_cnt_d;
        end
    end

    assign req_ack    = req_ack_q;
    assign req_done   = req_done_q;
    assign busy       = busy_q;
    assign bram_en    = bram_en_q;
    assign bram_addr  = bram_addr_q;
    assign icap_csib  = icap_csib_q;
    assign icap_rdwrb = 1'b0;
    assign icap_i     = icap_i_q;
    assign word_cnt   = word_cnt_q;

endmodule

// File: tb/tb_hapara_icap_sched.sv
// Scoreboard bench for hapara_icap_sched: a timeline model predicts every ack,
// BRAM read, ICAP write and done; a negedge monitor compares each cycle.
module tb_hapara_icap_sched;

    localparam int NR = 4;
    localparam int AW = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NR-1:0]    req_valid = '0;
    logic [NR*AW-1:0] req_addr = '0;
    logic [NR*AW-1:0] req_len = '0;
    logic [NR-1:0]    req_ack, req_done;
    logic             busy, bram_en, icap_csib, icap_rdwrb;
    logic [AW-1:0]    bram_addr;
    logic [31:0]      bram_dout = '0;
    logic [31:0]      icap_i, word_cnt;
    logic [NR-1:0]    ack_ns, done_ns;
    logic             busy_ns, en_ns, csib_ns, rdwrb_ns;
    logic [AW-1:0]    addr_ns;
    logic [31:0]      icap_i_ns, wcnt_ns;

    logic [31:0] mem [65536];

    hapara_icap_sched #(.NUM_REQ(NR), .DATA_WIDTH(32), .ADDR_WIDTH(AW), .SWAP_BITS(1'b1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_len(req_len),
        .req_ack(req_ack), .req_done(req_done), .busy(busy), .bram_en(bram_en),
        .bram_addr(bram_addr), .bram_dout(bram_dout), .icap_csib(icap_csib),
        .icap_rdwrb(icap_rdwrb), .icap_i(icap_i), .word_cnt(word_cnt)
    );

    hapara_icap_sched #(.NUM_REQ(NR), .DATA_WIDTH(32), .ADDR_WIDTH(AW), .SWAP_BITS(1'b0)) dut_ns (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_len(req_len),
        .req_ack(ack_ns), .req_done(done_ns), .busy(busy_ns), .bram_en(en_ns),
        .bram_addr(addr_ns), .bram_dout(bram_dout), .icap_csib(csib_ns),
        .icap_rdwrb(rdwrb_ns), .icap_i(icap_i_ns), .word_cnt(wcnt_ns)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bram_en) bram_dout <= mem[bram_addr];
    end

    typedef struct {
        int          cyc;
        logic [31:0] val;
    } ev_t;

    ev_t q_ack[$];
    ev_t q_done[$];
    ev_t q_rd[$];
    ev_t q_wr[$];

    int checks = 0;
    int errors = 0;
    int edge_n = 0;
    int rst_edge = -1;
    int next_free = 0;
    int busy_lo = 0;
    int busy_hi = -1;
    int m_ptr = 0;
    int grant_edge [NR] = '{default: -1};
    int m_g, m_a, m_l;
    logic [31:0] exp_wcnt = '0;
    logic [31:0] exp_icap = '0;
    logic [31:0] exp_icap_ns = '0;

    function automatic logic [31:0] swap_ref(input logic [31:0] w);
        logic [31:0] r;
        for (int k = 0; k < 32; k++) r[k] = w[(k / 8) * 8 + 7 - (k % 8)];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %h expected %h", nm, edge_n, act, exp);
        end
    endtask

    // Reference model: arbitration rule plus the transfer timeline, in edge numbers.
    always @(posedge clk) begin
        edge_n++;
        if (rst) begin
            rst_edge  = edge_n;
            m_ptr     = 0;
            next_free = edge_n + 1;
            busy_hi   = -1;
            q_ack.delete();
            q_done.delete();
            q_rd.delete();
            q_wr.delete();
        end else if (edge_n >= next_free && req_valid != '0) begin
            m_g = -1;
            for (int i = 0; i < NR; i++) begin
                if (m_g < 0 && req_valid[(m_ptr + i) % NR]) m_g = (m_ptr + i) % NR;
            end
            m_ptr = (m_g + 1) % NR;
            grant_edge[m_g] = edge_n;
            m_a = int'(req_addr[m_g*AW +: AW]);
            m_l = int'(req_len[m_g*AW +: AW]);
            q_ack.push_back('{edge_n, 32'(m_g)});
            for (int i = 0; i < m_l; i++) begin
                q_rd.push_back('{edge_n + i, 32'((m_a + i) % 65536)});
                q_wr.push_back('{edge_n + 2 + i, mem[(m_a + i) % 65536]});
            end
            busy_lo = edge_n;
            if (m_l == 0) begin
                q_done.push_back('{edge_n + 1, 32'(m_g)});
                busy_hi   = edge_n + 1;
                next_free = edge_n + 3;
            end else begin
                q_done.push_back('{edge_n + m_l + 2, 32'(m_g)});
                busy_hi   = edge_n + m_l + 2;
                next_free = edge_n + m_l + 4;
            end
        end
    end

    always @(negedge clk) begin
        logic [NR-1:0] e_ack, e_done;
        logic          e_en;
        if (edge_n > 0) begin
            if (rst_edge == edge_n) begin
                chk("rst_ack", 32'(req_ack), 0);
                chk("rst_done", 32'(req_done), 0);
                chk("rst_busy", 32'(busy), 0);
                chk("rst_bram_en", 32'(bram_en), 0);
                chk("rst_bram_addr", 32'(bram_addr), 0);
                chk("rst_csib", 32'(icap_csib), 1);
                chk("rst_icap_i", icap_i, 0);
                chk("rst_word_cnt", word_cnt, 0);
                exp_wcnt    = '0;
                exp_icap    = '0;
                exp_icap_ns = '0;
            end else begin
                e_ack = '0;
                if (q_ack.size() > 0 && q_ack[0].cyc == edge_n) begin
                    e_ack[q_ack[0].val[1:0]] = 1'b1;
                    void'(q_ack.pop_front());
                end
                chk("req_ack", 32'(req_ack), 32'(e_ack));
                e_en = 1'b0;
                if (q_rd.size() > 0 && q_rd[0].cyc == edge_n) begin
                    e_en = 1'b1;
                    chk("bram_addr", 32'(bram_addr), q_rd[0].val);
                    void'(q_rd.pop_front());
                end
                chk("bram_en", 32'(bram_en), 32'(e_en));
                if (q_wr.size() > 0 && q_wr[0].cyc == edge_n) begin
                    exp_icap    = swap_ref(q_wr[0].val);
                    exp_icap_ns = q_wr[0].val;
                    exp_wcnt    = exp_wcnt + 1;
                    chk("csib_write", 32'(icap_csib), 0);
                    chk("icap_i_ns", icap_i_ns, exp_icap_ns);
                    void'(q_wr.pop_front());
                end else begin
                    chk("csib_idle", 32'(icap_csib), 1);
                end
                chk("icap_i", icap_i, exp_icap);
                e_done = '0;
                if (q_done.size() > 0 && q_done[0].cyc == edge_n) begin
                    e_done[q_done[0].val[1:0]] = 1'b1;
                    chk("word_cnt", word_cnt, exp_wcnt);
                    void'(q_done.pop_front());
                end
                chk("req_done", 32'(req_done), 32'(e_done));
                chk("busy", 32'(busy), 32'(edge_n >= busy_lo && edge_n <= busy_hi));
                chk("rdwrb", 32'(icap_rdwrb), 0);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        for (int i = 0; i < NR; i++) begin
            if (req_valid[i] && grant_edge[i] == edge_n) req_valid[i] = 1'b0;
        end
    endtask

    task automatic post(input int i, input int a, input int l);
        req_addr[i*AW +: AW] = AW'(a);
        req_len[i*AW +: AW]  = AW'(l);
        req_valid[i]         = 1'b1;
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while ((q_ack.size() + q_done.size() + q_rd.size() + q_wr.size() > 0 ||
                edge_n < next_free || req_valid != '0) && n < limit) begin
            tick();
            n++;
        end
        if (n >= limit) chk("idle_timeout", 32'(n), 32'(limit - 1));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    initial begin
        int rearm;
        int n;
        for (int i = 0; i < 65536; i++) mem[i] = $urandom;
        mem[16'h0010] = 32'h000000FF;
        mem[16'h0011] = 32'h01020304;
        mem[16'h0012] = 32'h00000002;
        mem[16'h0013] = 32'h00000003;

        repeat (3) tick();
        rst = 1'b0;

        post(1, 16'h0010, 4);
        wait_idle(100);

        do_reset();
        for (int i = 0; i < NR; i++) post(i, 16'h0100 + 16 * i, 2);
        rearm = 1;
        for (int c = 0; c < 60; c++) begin
            tick();
            if (!req_valid[0] && rearm > 0) begin
                post(0, 16'h0400, 2);
                rearm--;
            end
        end
        wait_idle(200);

        post(2, 16'h0300, 0);
        wait_idle(100);
        post(0, 16'hFFFE, 4);
        wait_idle(100);

        post(1, 16'h0200, 8);
        n = 0;
        do begin
            tick();
            n++;
        end while (grant_edge[1] != edge_n && n < 100);
        if (n >= 100) chk("grant_timeout", 32'(n), 32'(99));
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        post(1, 16'h0500, 3);
        post(3, 16'h0600, 3);
        wait_idle(200);

        for (int c = 0; c < 2000; c++) begin
            tick();
            for (int i = 0; i < NR; i++) begin
                if (!req_valid[i]) begin
                    req_addr[i*AW +: AW] = AW'($urandom);
                    req_len[i*AW +: AW]  = AW'($urandom_range(0, 10));
                    if ($urandom_range(0, 7) == 0) begin
                        post(i, ($urandom_range(0, 3) == 0) ? int'($urandom_range(16'hFFF8, 16'hFFFF))
                                                             : int'($urandom_range(0, 16'hFFFF)),
                             int'($urandom_range(0, 10)));
                    end
                end else if ($urandom_range(0, 63) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
        end
        req_valid = '0;
        wait_idle(300);
        repeat (5) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
